data_mem_arbiter: RTL and testbench

Shares the single Data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/debug port, used to preload arrays and dump results).
- Data memory read is combinational; write commits on the rising clk edge when w_en is high; words are indexed by addr[15:0].
- The arbiter serialises requests, drives the memory's r_addr/w_addr/w_en/din, and returns registered read data with a one-cycle ack.

---
 rtl/data_mem_arb_pkg.sv | 20 ++
 rtl/data_mem_arbiter_rr_pick2.sv | 33 +++
 rtl/data_mem_arbiter.sv | 84 ++++++++
 tb/tb_data_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Port ids, FSM state encoding and the port one-hot helper.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int MEM_IDX_W = 16;

  function automatic logic [1:0] port_oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way request picker: round-robin on a tie, or strict loader
// priority when DATA_MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    unique case (1'b1)
      (req == 2'b11): begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
        winner = PORT_LDR;
`else
        winner = ~last_grant;
`endif
      end
      (req == 2'b10): winner = PORT_LDR;
      default:        winner = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises CPU and loader accesses onto the single data memory.
// Build option: DATA_MEM_ARB_FIXED_PRIO_EN gives the loader strict priority.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  output logic [ADDR_W-1:0] mem_w_addr_o,
  output logic              mem_w_en_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  state_t state;
  logic   win;
  logic   last_grant;
  logic   pick_win;
  logic   pick_valid;

  rr_pick2 u_pick (
    .req        (req_i),
    .last_grant (last_grant),
    .winner     (pick_win),
    .valid      (pick_valid)
  );

  assign busy_o       = (state != IDLE);
  assign mem_w_addr_o = mem_r_addr_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      win          <= PORT_CPU;
      last_grant   <= PORT_LDR;
      gnt_o        <= '0;
      ack_o        <= '0;
      rdata_o      <= '0;
      mem_r_addr_o <= '0;
      mem_din_o    <= '0;
      mem_w_en_o   <= 1'b0;
    end else begin
      gnt_o      <= '0;
      ack_o      <= '0;
      mem_w_en_o <= 1'b0;
      unique case (state)
        ACCESS: begin
          state <= RESP;
          ack_o <= port_oh(win);
          if (!mem_w_en_o)
            rdata_o <= mem_dout_i;
        end
        default: begin
          // IDLE and RESP share arbitration so back-to-back skips IDLE
          if (pick_valid) begin
            state        <= ACCESS;
            win          <= pick_win;
            last_grant   <= pick_win;
            gnt_o        <= port_oh(pick_win);
            mem_w_en_o   <= we_i[pick_win];
            mem_r_addr_o <= pick_win ? addr1_i : addr0_i;
            mem_din_o    <= pick_win ? wdata1_i : wdata0_i;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table plus
// hand-written multi-cycle sequences, acks checked via a scoreboard.
module tb_data_mem_arbiter;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic [1:0]  gnt_o;
  logic [1:0]  ack_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic [31:0] mem_r_addr_o;
  logic [31:0] mem_w_addr_o;
  logic        mem_w_en_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;

  data_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr0_i      (addr0_i),
    .addr1_i      (addr1_i),
    .wdata0_i     (wdata0_i),
    .wdata1_i     (wdata1_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .mem_r_addr_o (mem_r_addr_o),
    .mem_w_addr_o (mem_w_addr_o),
    .mem_w_en_o   (mem_w_en_o),
    .mem_din_o    (mem_din_o),
    .mem_dout_i   (mem_dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on rising edge
  logic [31:0] mem [0:65535];
  assign mem_dout_i = mem[mem_r_addr_o[15:0]];
  always @(posedge clk) if (mem_w_en_o) mem[mem_w_addr_o[15:0]] <= mem_din_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rd;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic sb_push(input logic port, input logic we, input logic [31:0] rd);
    sb_t e;
    if (!we) last_rd = rd;
    e.ack = oh(port);
    e.rd  = last_rd;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && ack_o != 2'b00) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got %b expected none", ack_o);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_ack", {62'd0, ack_o}, {62'd0, e.ack});
        check("sb_rdata", {32'd0, rdata_o}, {32'd0, e.rd});
      end
    end
    if (mem_w_en_o === 1'b1)
      check("wen_only_in_access", {63'd0, gnt_o != 2'b00}, 64'd1);
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_gnt"}, {62'd0, gnt_o}, 64'd0);
    check({tag, "_ack"}, {62'd0, ack_o}, 64'd0);
    check({tag, "_rdata"}, {32'd0, rdata_o}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_wen"}, {63'd0, mem_w_en_o}, 64'd0);
    check({tag, "_raddr"}, {32'd0, mem_r_addr_o}, 64'd0);
    check({tag, "_waddr"}, {32'd0, mem_w_addr_o}, 64'd0);
    check({tag, "_din"}, {32'd0, mem_din_o}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_i = 2'b00;
    @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b1;
    last_rd = '0;
  endtask

  task automatic drive(input logic port, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_i[port] = 1'b1;
    we_i[port]  = we;
    if (port) begin
      addr1_i  = addr;
      wdata1_i = wdata;
    end else begin
      addr0_i  = addr;
      wdata0_i = wdata;
    end
  endtask

  // Entered right after a negedge; leaves at a negedge with DUT idle
  task automatic do_txn(input vec_t v);
    drive(v.port, v.we, v.addr, v.wdata);
    sb_push(v.port, v.we, v.exp);
    @(negedge clk);
    check("txn_gnt", {62'd0, gnt_o}, {62'd0, oh(v.port)});
    check("txn_busy_acc", {63'd0, busy_o}, 64'd1);
    check("txn_raddr", {32'd0, mem_r_addr_o}, {32'd0, v.addr});
    check("txn_waddr", {32'd0, mem_w_addr_o}, {32'd0, v.addr});
    check("txn_wen_acc", {63'd0, mem_w_en_o}, {63'd0, v.we});
    if (v.we) check("txn_din", {32'd0, mem_din_o}, {32'd0, v.wdata});
    @(negedge clk);
    req_i[v.port] = 1'b0;
    check("txn_busy_resp", {63'd0, busy_o}, 64'd1);
    check("txn_wen_resp", {63'd0, mem_w_en_o}, 64'd0);
    check("txn_gnt_resp", {62'd0, gnt_o}, 64'd0);
    @(negedge clk);
    check("txn_busy_idle", {63'd0, busy_o}, 64'd0);
    check("txn_ack_idle", {62'd0, ack_o}, 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [1:0] first_oh;
    logic [1:0] second_oh;
    logic       p;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0,         32'd6};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 32'd99,        32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'd99};
    vecs[3] = '{1'b0, 1'b1, 32'h0001_0003, 32'd7,         32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         32'd7};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,         32'h0000_1234};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h0001_FFFF, 32'h0,         32'hDEAD_BEEF};

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0]     = 32'd35;
    mem[1]     = 32'd6;
    mem[2]     = 32'd67;
    mem[5]     = 32'd2;
    mem[8]     = 32'd11;
    mem[9]     = 32'd22;
    mem[16'hFFFF] = 32'h0000_1234;

    rst = 1'b0;
    req_i = 2'b00;
    we_i = 2'b00;
    addr0_i = '0;
    addr1_i = '0;
    wdata0_i = '0;
    wdata1_i = '0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    check("wrap_mem3", {32'd0, mem[3]}, 64'd7);

    // Simultaneous requests straight after reset
    do_reset();
    first_oh  = FIXED ? 2'b10 : 2'b01;
    second_oh = FIXED ? 2'b01 : 2'b10;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd2, 32'd0);
    if (FIXED) begin
      sb_push(1'b1, 1'b0, 32'd67);
      sb_push(1'b0, 1'b0, 32'd35);
    end else begin
      sb_push(1'b0, 1'b0, 32'd35);
      sb_push(1'b1, 1'b0, 32'd67);
    end
    @(negedge clk);
    check("tie_gnt1", {62'd0, gnt_o}, {62'd0, first_oh});
    @(negedge clk);
    req_i = req_i & ~first_oh;
    @(negedge clk);
    check("tie_gnt2", {62'd0, gnt_o}, {62'd0, second_oh});
    check("tie_busy2", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    req_i = 2'b00;
    @(negedge clk);
    check("tie_idle", {63'd0, busy_o}, 64'd0);

    // Both ports hold requests for six transactions
    drive(1'b0, 1'b0, 32'd8, 32'd0);
    drive(1'b1, 1'b0, 32'd9, 32'd0);
    for (int i = 0; i < 6; i++) begin
      p = FIXED ? 1'b1 : i[0];
      sb_push(p, 1'b0, p ? 32'd22 : 32'd11);
    end
    for (int i = 0; i < 6; i++) begin
      p = FIXED ? 1'b1 : i[0];
      @(negedge clk);
      check("rr_gnt", {62'd0, gnt_o}, {62'd0, oh(p)});
      @(negedge clk);
      if (i == 5) req_i = 2'b00;
    end
    @(negedge clk);
    check("rr_idle", {63'd0, busy_o}, 64'd0);

    // Reset in the middle of a store's ACCESS cycle
    drive(1'b0, 1'b1, 32'd5, 32'd55);
    @(negedge clk);
    check("rst_acc_wen", {63'd0, mem_w_en_o}, 64'd1);
    #1 rst = 1'b0;
    req_i = 2'b00;
    #1;
    check("rst_async_wen", {63'd0, mem_w_en_o}, 64'd0);
    check("rst_async_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    check("rst_mem5", {32'd0, mem[5]}, 64'd2);
    check_reset_outs("rst_mid");
    rst = 1'b1;
    last_rd = '0;
    @(negedge clk);
    check("rst_no_ack", {62'd0, ack_o}, 64'd0);

    do_txn('{1'b0, 1'b0, 32'd5, 32'd0, 32'd2});
    check("sb_empty", {32'd0, 32'(sbq.size())}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
